pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage ARMv8 (LEGv8 subset) datapath. Decides each cycle which pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) advance, hold or are flushed to a bubble. Covers:
- load-use hazards on LDUR;
- CBZ taken-branch flushes;
- data-memory wait states, with a timeout that halts the core.

Sits beside the control unit; consumes decoded fields from the ID, EX and MEM stages.

## Interface
- `MEM_TIMEOUT`, default 16: consecutive busy memory cycles that trigger a halt; must be ≥2.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `id_rn`  in  5  first source register of the instruction in ID
- `id_rm`  in  5  second source register of the instruction in ID (Rm or Rt, after Reg2Loc mux)
- `id_uses_rm`  in  1  instruction in ID reads `id_rm`
- `ex_memread`  in  1  MemRead of the instruction in EX
- `ex_rd`  in  5  destination register of the instruction in EX
- `mem_access`  in  1  MemRead or MemWrite of the instruction in MEM
- `dmem_ack`  in  1  data memory has completed the current access
- `mem_branch_taken`  in  1  Branch & Zero for the instruction in MEM
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  register load enables
- `ifid_flush`, `idex_flush`, `exmem_flush`  out  1 each  load a bubble (all control bits 0) instead of data
- `halted`  out  1  core halted by memory timeout (sticky)
- `mem_err`  out  1  memory timeout occurred (sticky)
- `stall_cnt`  out  `CNT_W`  cycles with `pc_en`=0 outside HALT, saturating
- `flush_cnt`  out  `CNT_W`  taken-branch flush cycles, saturating

## Operation
Derived signals, all combinational:
- `load_use = ex_memread & (ex_rd != 31) & ((ex_rd == id_rn) | (id_uses_rm & ex_rd == id_rm))`. X31 (XZR) never creates a hazard.
- `mem_busy = mem_access & ~dmem_ack`.

FSM states are RUN, WAIT and HALT. Per-cycle priority in RUN and WAIT is `mem_busy` > `mem_branch_taken` > `load_use` > normal:
- **`mem_busy`:** all five enables 0, all flushes 0 (full freeze).
- **`mem_branch_taken`:** all enables 1; `ifid_flush`, `idex_flush` and `exmem_flush` are 1; `flush_cnt`+1. The PC loads the branch target (the target mux is outside this block).
- **`load_use`:** `pc_en` and `ifid_en` are 0; `idex_en` is 1 with `idex_flush` 1 (bubble inserted); `exmem_en` and `memwb_en` are 1.
- **Normal:** all enables 1, all flushes 0.

State transitions:
- RUN→WAIT when `mem_busy`; `wait_cnt` is set to 1.
- WAIT: each busy cycle increments `wait_cnt`.
- WAIT→HALT when `mem_busy` and `wait_cnt == MEM_TIMEOUT-1`, i.e. on the MEM_TIMEOUT-th consecutive busy cycle. `mem_err` and `halted` are set at that edge.
- WAIT→RUN in the cycle `dmem_ack` arrives (`mem_busy`=0). That cycle follows the normal priority rules, so a branch or load-use pending behind the access is handled immediately.
- HALT: all enables 0, all flushes 0. Leaves only on `reset`; inputs are ignored.

Counters:
- `stall_cnt`+1 for every RUN/WAIT cycle with `pc_en`=0 (busy or load-use).
- Both counters saturate at 2^`CNT_W`-1 and do not wrap.
- Counter width follows `CNT_W` exactly.

## Timing
- Enables and flushes are Mealy outputs: they respond in the same cycle as their inputs. There is no latency from hazard detection to stall.
- A load-use stall lasts exactly 1 cycle. Next cycle the LDUR is in MEM, `ex_memread` is 0 from the bubble, so `load_use` clears.
- Branch flush lasts 1 cycle per taken branch. Simultaneous `mem_branch_taken` and `load_use`: flush wins and no bubble counting occurs (`stall_cnt` unchanged).
- Simultaneous `mem_busy` and `mem_branch_taken`: freeze wins. The flush happens in the `dmem_ack` cycle.
- Reset:
  - While `reset`=1: all enables 0, all flushes 1, `halted`=0, `mem_err`=0, counters 0, state RUN, `wait_cnt` 0.
  - Deassertion is synchronized by the datapath. The first clock edge after it operates in RUN.
  - Reset mid-WAIT or mid-HALT aborts immediately to these values.

## Test plan
- `ex_memread`=1, `ex_rd`=3, `id_rn`=3, no busy/branch → `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `exmem_en`=1; `stall_cnt` 0→1.
- `ex_memread`=1, `ex_rd`=31, `id_rn`=31 → no stall. `id_uses_rm`=0 with `ex_rd`=`id_rm`=5 → no stall.
- `mem_branch_taken`=1 together with `load_use`=1 → all enables 1, three flushes 1; `flush_cnt`+1, `stall_cnt` unchanged.
- `mem_access`=1 with `dmem_ack` low for 3 cycles, then high → 3 frozen cycles in WAIT, RUN on the ack cycle, `stall_cnt`=3, `mem_err`=0.
- `MEM_TIMEOUT`=4, `dmem_ack` held low → HALT after 4th busy cycle, `halted`=`mem_err`=1. A later `dmem_ack` keeps all enables 0. `reset` pulse clears to the reset values.
- `CNT_W`=2, 5 branch flushes → `flush_cnt` reads 3 (saturated).

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencing for the five-stage LEGv8 pipeline
// covering load-use bubbles, CBZ flushes and data-memory wait states with a timeout halt.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rm,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             mem_access,
    input  logic             dmem_ack,
    input  logic             mem_branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {RUN, WAIT, HALT} state_e;
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] LAST = WW'(MEM_TIMEOUT - 1);
    state_e           state_q, state_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             mem_err_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             load_use, mem_busy, active, br, lu;
    assign load_use = ex_memread & (ex_rd != 5'd31) &
                      ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm)));
    assign mem_busy = mem_access & ~dmem_ack;
    assign active   = ~reset & (state_q != HALT);
    // priority: busy freeze > branch flush > load-use bubble
    assign br = ~mem_busy & mem_branch_taken;
    assign lu = ~mem_busy & ~mem_branch_taken & load_use;
    assign pc_en       = active & ~mem_busy & ~lu;
    assign ifid_en     = pc_en;
    assign idex_en     = active & ~mem_busy;
    assign exmem_en    = idex_en;
    assign memwb_en    = idex_en;
    assign ifid_flush  = reset | (active & br);
    assign idex_flush  = reset | (active & (br | lu));
    assign exmem_flush = reset | (active & br);
    assign halted      = state_q == HALT;
    assign mem_err     = mem_err_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (state_q != HALT) begin
            if (!mem_busy) begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end else if (state_q == RUN) begin
                state_d    = WAIT;
                wait_cnt_d = WW'(1);
            end else begin
                state_d    = (wait_cnt_q == LAST) ? HALT : WAIT;
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
        stall_cnt_d = (active && !pc_en && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (active && br && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_q | (state_d == HALT);
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: two instances (timeout 4 / 16-bit counters, timeout 6 / 2-bit counters)
// share stimulus; a queue-based scoreboard checks both against an abstract model.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] id_rn = '0, id_rm = '0, ex_rd = '0;
    logic id_uses_rm = 1'b0, ex_memread = 1'b0, mem_access = 1'b0, dmem_ack = 1'b0, mem_branch_taken = 1'b0;
    logic pc0, ifid0, idex0, exmem0, memwb0, fif0, fix0, fxm0, h0, e0;
    logic pc1, ifid1, idex1, exmem1, memwb1, fif1, fix1, fxm1, h1, e1;
    logic [15:0] sc0, fc0;
    logic [1:0] sc1, fc1;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_access(mem_access), .dmem_ack(dmem_ack),
        .mem_branch_taken(mem_branch_taken), .pc_en(pc0), .ifid_en(ifid0), .idex_en(idex0),
        .exmem_en(exmem0), .memwb_en(memwb0), .ifid_flush(fif0), .idex_flush(fix0),
        .exmem_flush(fxm0), .halted(h0), .mem_err(e0), .stall_cnt(sc0), .flush_cnt(fc0));

    pipe_hazard_ctrl #(.MEM_TIMEOUT(6), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_access(mem_access), .dmem_ack(dmem_ack),
        .mem_branch_taken(mem_branch_taken), .pc_en(pc1), .ifid_en(ifid1), .idex_en(idex1),
        .exmem_en(exmem1), .memwb_en(memwb1), .ifid_flush(fif1), .idex_flush(fix1),
        .exmem_flush(fxm1), .halted(h1), .mem_err(e1), .stall_cnt(sc1), .flush_cnt(fc1));

    typedef struct packed {
        logic [4:0]  en;
        logic [2:0]  fl;
        logic        h;
        logic        e;
        logic [15:0] sc;
        logic [15:0] fc;
    } obs_t;
    typedef struct packed {
        obs_t a;
        obs_t b;
    } pair_t;
    pair_t sbq[$];

    // model state: consecutive busy cycles, halt flag, integer counters
    int m_run[2], m_sc[2], m_fc[2];
    bit m_halt[2];
    int to_lim[2] = '{4, 6};
    int cnt_max[2] = '{65535, 3};

    function automatic bit hazard();
        return ex_memread && ex_rd != 31 && (ex_rd == id_rn || (id_uses_rm && ex_rd == id_rm));
    endfunction

    function automatic obs_t model_out(int k);
        obs_t o;
        bit busy;
        busy = mem_access && !dmem_ack;
        o.h = m_halt[k];
        o.e = m_halt[k];
        o.sc = 16'(m_sc[k]);
        o.fc = 16'(m_fc[k]);
        if (reset) begin
            o.en = 5'b00000; o.fl = 3'b111; o.h = 0; o.e = 0; o.sc = 0; o.fc = 0;
        end else if (m_halt[k] || busy) begin
            o.en = 5'b00000; o.fl = 3'b000;
        end else if (mem_branch_taken) begin
            o.en = 5'b11111; o.fl = 3'b111;
        end else if (hazard()) begin
            o.en = 5'b00111; o.fl = 3'b010;
        end else begin
            o.en = 5'b11111; o.fl = 3'b000;
        end
        return o;
    endfunction

    task automatic model_update(int k);
        bit busy;
        busy = mem_access && !dmem_ack;
        if (reset) begin
            m_run[k] = 0; m_halt[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end else if (!m_halt[k]) begin
            if (busy) begin
                m_run[k]++;
                if (m_sc[k] < cnt_max[k]) m_sc[k]++;
                if (m_run[k] >= to_lim[k]) m_halt[k] = 1;
            end else begin
                m_run[k] = 0;
                if (mem_branch_taken) begin
                    if (m_fc[k] < cnt_max[k]) m_fc[k]++;
                end else if (hazard()) begin
                    if (m_sc[k] < cnt_max[k]) m_sc[k]++;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic [4:0] rn, input logic [4:0] rm, input logic urm,
                        input logic exmr, input logic [4:0] exrd, input logic ma, input logic ack,
                        input logic brt);
        pair_t p;
        reset = r; id_rn = rn; id_rm = rm; id_uses_rm = urm; ex_memread = exmr; ex_rd = exrd;
        mem_access = ma; dmem_ack = ack; mem_branch_taken = brt;
        p.a = model_out(0);
        p.b = model_out(1);
        sbq.push_back(p);
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
    endtask

    task automatic idle();
        step(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input obs_t a, input obs_t x);
        chk({tag, ".enables"}, int'(a.en), int'(x.en));
        chk({tag, ".flushes"}, int'(a.fl), int'(x.fl));
        chk({tag, ".halted"}, int'(a.h), int'(x.h));
        chk({tag, ".mem_err"}, int'(a.e), int'(x.e));
        chk({tag, ".stall_cnt"}, int'(a.sc), int'(x.sc));
        chk({tag, ".flush_cnt"}, int'(a.fc), int'(x.fc));
    endtask

    always @(negedge clk) begin
        pair_t x;
        obs_t a0, a1;
        if (sbq.size() > 0) begin
            x = sbq.pop_front();
            a0.en = {pc0, ifid0, idex0, exmem0, memwb0};
            a0.fl = {fif0, fix0, fxm0};
            a0.h = h0; a0.e = e0; a0.sc = sc0; a0.fc = fc0;
            a1.en = {pc1, ifid1, idex1, exmem1, memwb1};
            a1.fl = {fif1, fix1, fxm1};
            a1.h = h1; a1.e = e1; a1.sc = {14'b0, sc1}; a1.fc = {14'b0, fc1};
            cmp("d0", a0, x.a);
            cmp("d1", a1, x.b);
        end
    end

    function automatic logic [4:0] rreg();
        int v;
        v = $urandom_range(0, 4);
        return (v == 4) ? 5'd31 : 5'(v);
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_halt[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        // load-use on X3, then bubble clears
        step(0, 5'd3, 5'd7, 1, 1, 5'd3, 0, 1, 0);
        idle();
        // XZR never stalls; unused Rm never stalls
        step(0, 5'd31, 5'd2, 1, 1, 5'd31, 0, 1, 0);
        step(0, 5'd0, 5'd5, 0, 1, 5'd5, 0, 1, 0);
        step(0, 5'd0, 5'd5, 1, 1, 5'd5, 0, 1, 0);
        // branch beats load-use
        step(0, 5'd4, 5'd4, 1, 1, 5'd4, 0, 1, 1);
        // three busy cycles then ack, with a branch waiting behind the access
        repeat (3) step(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, 1);
        step(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 1, 1);
        idle();
        // repeated flushes saturate the narrow counter
        repeat (5) step(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 1);
        idle();
        // randomized traffic with occasional resets
        repeat (600) begin
            step(($urandom_range(0, 79) == 0), rreg(), rreg(), 1'($urandom), 1'($urandom),
                 rreg(), ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 9) < 2));
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        // memory never acks: both instances hit their timeouts
        repeat (8) step(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 0, 0);
        repeat (3) step(0, 5'd3, 5'd2, 1, 1, 5'd3, 1, 1, 1);
        step(1, 5'd3, 5'd2, 1, 1, 5'd3, 1, 0, 1);
        idle();
        step(0, 5'd3, 5'd7, 1, 1, 5'd3, 0, 1, 0);
        idle();
        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
